lpc_record_fifo: RTL and testbench

Downstream stage of the LPC cycle decoder. Captures each completed I/O-read record (cycle type/direction, 16-bit address, data byte) on the rising edge of the decoder's completion strobe, buffers records in a FIFO, and serializes each one as a 4-byte frame on a valid/ready byte stream for the UART transmitter. Drops are counted, and flagged in the next emitted frame.

---
 rtl/lpc_record_fifo_if.sv | 25 ++
 rtl/lpc_record_fifo.sv | 196 +++++++++++++++++++
 tb/tb_lpc_record_fifo.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_record_fifo_if.sv
// Record-capture and byte-stream bundle between the LPC cycle decoder, the
// record FIFO and the UART transmitter.
interface lpc_record_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic [3:0]            in_cyctype_dir;
  logic [31:0]           in_addr;
  logic [7:0]            in_data;
  logic                  in_clock_enable;
  logic [7:0]            out_byte;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            overflow_count;
  logic [DEPTH_LOG2:0]   fifo_level;

  modport master (
    output in_cyctype_dir, in_addr, in_data, in_clock_enable, out_ready,
    input  out_byte, out_valid, overflow_count, fifo_level
  );

  modport slave (
    input  in_cyctype_dir, in_addr, in_data, in_clock_enable, out_ready,
    output out_byte, out_valid, overflow_count, fifo_level
  );
endinterface

// File: rtl/lpc_record_fifo.sv
// Buffers completed LPC I/O-read records and serializes each as a 4-byte
// frame {type/lost, addr hi, addr lo, data} on a valid/ready byte stream.
module lpc_record_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             lpc_clock,
  input  logic             reset,
  lpc_record_fifo_if.slave bus
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 29;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    BYTE2 = 3'd3,
    BYTE3 = 3'd4
  } ser_state_t;

  // Entry layout: {cyctype_dir[28:25], lost[24], addr[23:8], data[7:0]}
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] e, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {e[28:25], 3'b000, e[24]};
      2'd1:    b = e[23:16];
      2'd2:    b = e[15:8];
      default: b = e[7:0];
    endcase
    return b;
  endfunction

  logic                  strobe_q_r;
  logic                  rise_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  pop_s;
  logic                  accept_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic [ENTRY_W-1:0]    mem_r [DEPTH];
  logic [ENTRY_W-1:0]    entry_s;
  logic [ENTRY_W-1:0]    head_s;
  logic                  pending_lost_r;
  logic [7:0]            overflow_count_r;
  ser_state_t            state_r;
  ser_state_t            state_next_s;
  logic [ENTRY_W-1:0]    frame_r;
  logic [ENTRY_W-1:0]    frame_next_s;
  logic [7:0]            out_byte_r;
  logic [7:0]            out_byte_next_s;
  logic                  out_valid_r;
  logic                  out_valid_next_s;
  logic                  unused_addr_s;

  assign rise_s   = bus.in_clock_enable & ~strobe_q_r;
  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign full_s   = level_r[DEPTH_LOG2];
  assign empty_s  = (level_r == {(DEPTH_LOG2+1){1'b0}});
  assign push_s   = rise_s & ~full_s;
  assign drop_s   = rise_s & full_s;
  assign accept_s = out_valid_r & bus.out_ready;
  assign entry_s  = {bus.in_cyctype_dir, pending_lost_r, bus.in_addr[15:0], bus.in_data};
  assign head_s   = mem_r[rd_ptr_r];

  assign unused_addr_s = &{1'b0, bus.in_addr[31:16]};

  assign bus.out_byte       = out_byte_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.overflow_count = overflow_count_r;
  assign bus.fifo_level     = level_r;

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge lpc_clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Strobe edge detect, FIFO pointers/level, and drop bookkeeping.
  always_ff @(posedge lpc_clock or posedge reset) begin
    if (reset) begin
      strobe_q_r       <= 1'b1;
      wr_ptr_r         <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r         <= {DEPTH_LOG2{1'b0}};
      level_r          <= {(DEPTH_LOG2+1){1'b0}};
      pending_lost_r   <= 1'b0;
      overflow_count_r <= 8'd0;
    end else begin
      strobe_q_r <= bus.in_clock_enable;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
      if (push_s) begin
        pending_lost_r <= 1'b0;
      end else if (drop_s) begin
        pending_lost_r <= 1'b1;
      end
      if (drop_s && (overflow_count_r != 8'hFF)) begin
        overflow_count_r <= overflow_count_r + 8'd1;
      end
    end
  end

  // Serializer next state: pops a record into the frame register and steps bytes on handshakes.
  always_comb begin
    state_next_s     = state_r;
    frame_next_s     = frame_r;
    out_byte_next_s  = out_byte_r;
    out_valid_next_s = out_valid_r;
    pop_s            = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s            = 1'b1;
          frame_next_s     = head_s;
          out_byte_next_s  = frame_byte(head_s, 2'd0);
          out_valid_next_s = 1'b1;
          state_next_s     = BYTE0;
        end else begin
          out_valid_next_s = 1'b0;
          state_next_s     = IDLE;
        end
      end
      BYTE0: begin
        if (accept_s) begin
          out_byte_next_s = frame_byte(frame_r, 2'd1);
          state_next_s    = BYTE1;
        end else begin
          state_next_s = BYTE0;
        end
      end
      BYTE1: begin
        if (accept_s) begin
          out_byte_next_s = frame_byte(frame_r, 2'd2);
          state_next_s    = BYTE2;
        end else begin
          state_next_s = BYTE1;
        end
      end
      BYTE2: begin
        if (accept_s) begin
          out_byte_next_s = frame_byte(frame_r, 2'd3);
          state_next_s    = BYTE3;
        end else begin
          state_next_s = BYTE2;
        end
      end
      BYTE3: begin
        if (accept_s && !empty_s) begin
          // Back-to-back frames: next record loads on the same handshake.
          pop_s            = 1'b1;
          frame_next_s     = head_s;
          out_byte_next_s  = frame_byte(head_s, 2'd0);
          out_valid_next_s = 1'b1;
          state_next_s     = BYTE0;
        end else if (accept_s) begin
          out_valid_next_s = 1'b0;
          state_next_s     = IDLE;
        end else begin
          state_next_s = BYTE3;
        end
      end
      default: begin
        out_valid_next_s = 1'b0;
        state_next_s     = IDLE;
      end
    endcase
  end

  // Serializer state, frame register and registered stream outputs.
  always_ff @(posedge lpc_clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      frame_r     <= {ENTRY_W{1'b0}};
      out_byte_r  <= 8'd0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      frame_r     <= frame_next_s;
      out_byte_r  <= out_byte_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end
endmodule

// File: tb/tb_lpc_record_fifo.sv
// Directed self-checking bench for lpc_record_fifo (DEPTH_LOG2 = 4).
module tb_lpc_record_fifo;
  logic lpc_clock = 1'b0;
  logic lpc_reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle        = 0;
  logic [7:0] got_q [$];
  int         got_cyc_q [$];
  logic [7:0] exp_three [12];
  logic [7:0] exp_bp [4];
  logic [7:0] held_byte;
  logic       stalled;

  lpc_record_fifo_if #(.DEPTH_LOG2(4)) bus ();

  lpc_record_fifo #(.DEPTH_LOG2(4)) dut (
    .lpc_clock (lpc_clock),
    .reset     (lpc_reset),
    .bus       (bus.slave)
  );

  always #5 lpc_clock = ~lpc_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qbyte(input int i);
    if (i < got_q.size()) return {24'd0, got_q[i]};
    else return 32'hFFFF_FFFF;
  endfunction

  // One clock: log a handshake mid-cycle, then settle 1 time unit past the edge.
  task automatic tick();
    @(negedge lpc_clock);
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_byte);
      got_cyc_q.push_back(cycle);
    end
    @(posedge lpc_clock);
    #1;
    cycle++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [3:0] cyc, input logic [15:0] addr, input logic [7:0] data);
    bus.in_cyctype_dir  = cyc;
    bus.in_addr         = {16'hDEAD, addr};
    bus.in_data         = data;
    bus.in_clock_enable = 1'b1;
    tick();
    bus.in_clock_enable = 1'b0;
    tick();
  endtask

  initial begin
    lpc_reset           = 1'b1;
    bus.in_cyctype_dir  = 4'h0;
    bus.in_addr         = 32'h0;
    bus.in_data         = 8'h00;
    bus.in_clock_enable = 1'b0;
    bus.out_ready       = 1'b0;
    exp_three = '{8'h00, 8'h00, 8'h60, 8'h11,
                  8'h20, 8'h00, 8'h64, 8'h22,
                  8'h00, 8'h03, 8'hF8, 8'h33};
    exp_bp    = '{8'h00, 8'h03, 8'hF8, 8'hC3};

    repeat (3) @(posedge lpc_clock);
    #1;
    lpc_reset = 1'b0;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_byte", {24'd0, bus.out_byte}, 32'd0);
    check("rst_ovf", {24'd0, bus.overflow_count}, 32'd0);
    check("rst_level", {27'd0, bus.fifo_level}, 32'd0);
    tick();

    // Single record, 2-cycle latency, 4 consecutive bytes
    bus.out_ready = 1'b1;
    got_q.delete();
    bus.in_cyctype_dir  = 4'h0;
    bus.in_addr         = 32'h0000_0080;
    bus.in_data         = 8'h5A;
    bus.in_clock_enable = 1'b1;
    tick();
    check("t1_level_push", {27'd0, bus.fifo_level}, 32'd1);
    check("t1_valid_early", {31'd0, bus.out_valid}, 32'd0);
    bus.in_clock_enable = 1'b0;
    tick();
    check("t1_valid_b0", {31'd0, bus.out_valid}, 32'd1);
    check("t1_b0", {24'd0, bus.out_byte}, 32'h00);
    check("t1_level_pop", {27'd0, bus.fifo_level}, 32'd0);
    tick();
    check("t1_b1", {24'd0, bus.out_byte}, 32'h00);
    tick();
    check("t1_b2", {24'd0, bus.out_byte}, 32'h80);
    tick();
    check("t1_b3", {24'd0, bus.out_byte}, 32'h5A);
    tick();
    check("t1_valid_end", {31'd0, bus.out_valid}, 32'd0);
    check("t1_count", got_q.size(), 32'd4);

    // Three rises 3 cycles apart: 12 contiguous bytes
    got_q.delete();
    got_cyc_q.delete();
    send(4'h0, 16'h0060, 8'h11);
    tick();
    send(4'h2, 16'h0064, 8'h22);
    tick();
    send(4'h0, 16'h03F8, 8'h33);
    ticks(14);
    check("t2_count", got_q.size(), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t2_byte%0d", i), qbyte(i), {24'd0, exp_three[i]});
    end
    if (got_cyc_q.size() == 12) begin
      check("t2_span", got_cyc_q[11] - got_cyc_q[0], 32'd11);
    end else begin
      check("t2_span_size", got_cyc_q.size(), 32'd12);
    end

    // Backpressure: ready pattern 1,0,0 repeating
    bus.out_ready = 1'b0;
    got_q.delete();
    send(4'h0, 16'h03F8, 8'hC3);
    check("t3_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus.out_ready = ((i % 3) == 0);
      @(negedge lpc_clock);
      stalled   = bus.out_valid & ~bus.out_ready;
      held_byte = bus.out_byte;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_byte);
      @(posedge lpc_clock);
      #1;
      cycle++;
      if (stalled) check($sformatf("t3_hold%0d", i), {24'd0, bus.out_byte}, {24'd0, held_byte});
    end
    check("t3_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_byte%0d", i), qbyte(i), {24'd0, exp_bp[i]});
    end
    check("t3_valid_end", {31'd0, bus.out_valid}, 32'd0);

    // Overflow: 18 rises, ready low
    bus.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) send(4'h0, 16'h0100 + 16'(i), 8'(i));
    check("t4_level_full", {27'd0, bus.fifo_level}, 32'd16);
    check("t4_ovf", {24'd0, bus.overflow_count}, 32'd1);
    check("t4_valid_held", {31'd0, bus.out_valid}, 32'd1);
    got_q.delete();
    bus.out_ready = 1'b1;
    ticks(75);
    check("t4_drain_count", got_q.size(), 32'd68);
    check("t4_drain_level", {27'd0, bus.fifo_level}, 32'd0);
    check("t4_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    got_q.delete();
    send(4'h0, 16'h1234, 8'hAB);
    check("t4_lost_b0_live", {24'd0, bus.out_byte}, 32'h01);
    ticks(4);
    send(4'h0, 16'h5678, 8'hCD);
    ticks(6);
    check("t4_post_count", got_q.size(), 32'd8);
    check("t4_lost_b0", qbyte(0), 32'h01);
    check("t4_lost_b2", qbyte(2), 32'h34);
    check("t4_next_b0", qbyte(4), 32'h00);
    check("t4_next_b3", qbyte(7), 32'hCD);

    // Saturation after 300 drops, then a long strobe captures once
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(4'h0, 16'h0200, 8'h00);
    for (int i = 0; i < 300; i++) send(4'h0, 16'h0201, 8'h01);
    check("t5_ovf_sat", {24'd0, bus.overflow_count}, 32'd255);
    check("t5_level", {27'd0, bus.fifo_level}, 32'd16);
    bus.out_ready = 1'b1;
    ticks(75);
    check("t5_drain_level", {27'd0, bus.fifo_level}, 32'd0);
    got_q.delete();
    bus.in_cyctype_dir  = 4'h0;
    bus.in_addr         = 32'h0000_0300;
    bus.in_data         = 8'h77;
    bus.in_clock_enable = 1'b1;
    ticks(10);
    bus.in_clock_enable = 1'b0;
    ticks(10);
    check("t5_once_count", got_q.size(), 32'd4);
    check("t5_once_b0", qbyte(0), 32'h01);
    check("t5_once_b3", qbyte(3), 32'h77);
    check("t5_ovf_hold", {24'd0, bus.overflow_count}, 32'd255);

    // Reset mid-frame after B1 accepted, 3 records queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'h0, 16'h04A0 + 16'(i), 8'h40 + 8'(i));
    check("t6_level", {27'd0, bus.fifo_level}, 32'd3);
    bus.out_ready = 1'b1;
    ticks(2);
    bus.out_ready = 1'b0;
    check("t6_b2_pending", {24'd0, bus.out_byte}, 32'hA0);
    lpc_reset           = 1'b1;
    bus.in_clock_enable = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_async_level", {27'd0, bus.fifo_level}, 32'd0);
    check("t6_async_ovf", {24'd0, bus.overflow_count}, 32'd0);
    tick();
    lpc_reset     = 1'b0;
    bus.out_ready = 1'b1;
    got_q.delete();
    ticks(4);
    check("t6_quiet_count", got_q.size(), 32'd0);
    check("t6_quiet_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_quiet_level", {27'd0, bus.fifo_level}, 32'd0);
    bus.in_clock_enable = 1'b0;
    tick();
    send(4'h0, 16'h0555, 8'h99);
    check("t6_new_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t6_new_b0", {24'd0, bus.out_byte}, 32'h00);
    ticks(4);
    check("t6_new_count", got_q.size(), 32'd4);
    check("t6_new_b2", qbyte(2), 32'h55);
    check("t6_new_b3", qbyte(3), 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
